// File: rtl/multi_player.sv
// Single-clock multi-channel sample player: DEPTH-frame RAM, one frame per tick, optional looping.
// Build option: define PLAYER_LOOP_EN to honour the loop input (otherwise playback is always one-shot).
module multi_player #(
  parameter int SAMPLE_W = 32,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         w_enable,
  input  logic [ADDR_W-1:0]            w_addr,
  input  logic [CHANNELS*SAMPLE_W-1:0] w_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic [ADDR_W:0]              length,
  input  logic                         loop,
  input  logic                         tick,
  output logic [CHANNELS*SAMPLE_W-1:0] out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);
  localparam int FW    = CHANNELS * SAMPLE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_pend_q, done_pend_d;
  logic [FW-1:0]     rd_data_q;
  logic [FW-1:0]     hold_q;
  logic [FW-1:0]     mem [DEPTH];
  logic [ADDR_W:0]   len_clip;
  logic              loop_en;

`ifdef PLAYER_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  assign len_clip = (length > DEPTH_L) ? DEPTH_L : length;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    rd_pend_d   = 1'b0;
    done_pend_d = 1'b0;
    if (stop) begin
      state_d   = S_IDLE;
      rd_addr_d = '0;
    end else if (state_q == S_IDLE) begin
      if (start && (length != '0)) begin
        state_d   = S_PLAY;
        len_d     = len_clip;
        rd_addr_d = '0;
      end
    end else begin
      // A read issued alongside a restart still delivers its frame.
      rd_pend_d = tick;
      if (start) begin
        rd_addr_d = '0;
        if (length != '0) len_d = len_clip;
        else              state_d = S_IDLE;
      end else if (tick) begin
        if (rd_addr_q == (len_q - ONE)) begin
          rd_addr_d = '0;
          if (!loop_en) begin
            state_d     = S_IDLE;
            done_pend_d = 1'b1;
          end
        end else begin
          rd_addr_d = rd_addr_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      len_q       <= '0;
      rd_pend_q   <= 1'b0;
      done_pend_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      rd_pend_q   <= rd_pend_d;
      done_pend_q <= done_pend_d;
      if (out_valid) hold_q <= rd_data_q;
    end
  end

  // Sample RAM: non-blocking write/read gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (w_enable) mem[w_addr] <= w_data;
    if (rd_pend_d) rd_data_q <= mem[rd_addr_q[ADDR_W-1:0]];
  end

  // out_valid is a one-cycle strobe with no back-pressure: out_data carries the frame read on the
  // previous tick; a stop in the same cycle cancels both the strobe and any done.
  assign out_valid = rd_pend_q & ~stop;
  assign done      = done_pend_q & ~stop;
  assign out_data  = out_valid ? rd_data_q : hold_q;
  assign busy      = (state_q == S_PLAY);

endmodule

// File: tb/tb_multi_player.sv
// Directed bench for multi_player: scoreboard queue of expected frames, checked on every out_valid.
module tb_multi_player;
  localparam int SAMPLE_W = 32;
  localparam int CHANNELS = 2;
  localparam int ADDR_W   = 10;
  localparam int FW       = CHANNELS * SAMPLE_W;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              w_enable;
  logic [ADDR_W-1:0] w_addr;
  logic [FW-1:0]     w_data;
  logic              start, stop, loop, tick;
  logic [ADDR_W:0]   length;
  logic [FW-1:0]     out_data;
  logic              out_valid, busy, done;

  logic [FW-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  multi_player #(.SAMPLE_W(SAMPLE_W), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .start(start), .stop(stop), .length(length), .loop(loop), .tick(tick),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] frame(input int n);
    logic [SAMPLE_W-1:0] c0, c1;
    c0 = SAMPLE_W'(n);
    c1 = SAMPLE_W'(32'h100 + n);
    return {c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once(input int gap);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (gap) step();
  endtask

  task automatic start_play(input int len);
    length = (ADDR_W+1)'(len);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Scoreboard side: every out_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      else                   chk("out_data", out_data, exp_q.pop_front());
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_with_valid", 64'(out_valid), 64'd1);
      chk("done_busy_low", 64'(busy), 64'd0);
    end
  end

  initial begin
    reset_n = 1'b0; w_enable = 1'b0; w_addr = '0; w_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; tick = 1'b0; length = '0;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    reset_n = 1'b1;
    step();

    for (int n = 0; n < DEPTH; n++) begin
      w_enable = 1'b1;
      w_addr   = ADDR_W'(n);
      w_data   = frame(n);
      step();
    end
    w_enable = 1'b0;
    step();

    // One-shot, tick every 3 cycles.
    done_cnt = 0;
    start_play(4);
    chk("t1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(frame(k));
      tick_once(2);
    end
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_hold", out_data, frame(3));

    // Loop request, length 3, eight ticks.
    done_cnt = 0;
    loop = 1'b1;
    start_play(3);
`ifdef PLAYER_LOOP_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(frame(k % 3));
`else
    for (int k = 0; k < 3; k++) exp_q.push_back(frame(k));
`endif
    for (int k = 0; k < 8; k++) tick_once(1);
    step();
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef PLAYER_LOOP_EN
    chk("t2_done_cnt", 64'(done_cnt), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_hold", out_data, frame(1));
    stop = 1'b1;
    step();
    stop = 1'b0;
`else
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_hold", out_data, frame(2));
`endif
    chk("t2_busy_end", 64'(busy), 64'd0);
    loop = 1'b0;
    step();

    // Stop while the second read is in flight.
    done_cnt = 0;
    start_play(8);
    exp_q.push_back(frame(0));
    tick_once(2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    stop = 1'b1;
    #1;
    chk("t3_stop_drops_valid", 64'(out_valid), 64'd0);
    step();
    stop = 1'b0;
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_hold", out_data, frame(0));
    tick_once(2);
    chk("t3_done_cnt", 64'(done_cnt), 64'd0);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length start ignored; start+stop together stays idle.
    start_play(0);
    chk("t4_len0_busy", 64'(busy), 64'd0);
    tick_once(1);
    tick_once(1);
    stop = 1'b1;
    start_play(5);
    stop = 1'b0;
    chk("t4_start_stop_busy", 64'(busy), 64'd0);
    tick_once(1);
    chk("t4_done_cnt", 64'(done_cnt), 64'd0);

    // Restart during PLAY with a tick in the same cycle.
    done_cnt = 0;
    start_play(8);
    exp_q.push_back(frame(0));
    tick_once(1);
    exp_q.push_back(frame(1));
    tick_once(1);
    exp_q.push_back(frame(2));
    length = (ADDR_W+1)'(2);
    start = 1'b1;
    tick  = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b0;
    step();
    chk("t4r_busy", 64'(busy), 64'd1);
    exp_q.push_back(frame(0));
    tick_once(1);
    exp_q.push_back(frame(1));
    tick_once(2);
    chk("t4r_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t4r_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4r_hold", out_data, frame(1));

    // Oversize length clamps to DEPTH, tick every cycle.
    done_cnt = 0;
    start_play(DEPTH + 1);
    tick = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(frame(k));
      step();
    end
    tick = 1'b0;
    repeat (3) step();
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_last", out_data, frame(DEPTH - 1));

    // Asynchronous reset mid-PLAY with a read in flight.
    done_cnt = 0;
    start_play(8);
    exp_q.push_back(frame(0));
    tick_once(1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    start_play(3);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(frame(k));
      tick_once(1);
    end
    step();
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
    chk("t6_hold", out_data, frame(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
